// File: rtl/led_scan_pkg.sv
// Shared types and default sizes for the multiplexed RGB LED scanner.
package led_scan_pkg;

    localparam int LSP_NUM_LEDS     = 7;
    localparam int LSP_PWM_BITS     = 8;
    localparam int LSP_BLANK_CYCLES = 4;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [LSP_PWM_BITS-1:0] r;
        logic [LSP_PWM_BITS-1:0] g;
        logic [LSP_PWM_BITS-1:0] b;
    } rgb_t;

endpackage

// File: rtl/led_pwm_cmp.sv
// One colour channel of the PWM stage: the active-low output is lit while the
// slot counter is still below the channel duty.
module led_pwm_cmp
    import led_scan_pkg::*;
#(
    parameter int PWM_BITS = LSP_PWM_BITS
) (
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] duty,
    output logic                lit_n
);

    assign lit_n = (pwm_cnt >= duty);

endmodule

// File: rtl/led_scan_pwm.sv
// led_scan_pwm: time-multiplexed LED enable scan with per-slot RGB PWM and a double-buffered duty store.
// Optional build macro LED_SCAN_PWM_GAMMA_EN squares each duty (d*d >> PWM_BITS) when the active buffer loads.
module led_scan_pwm
    import led_scan_pkg::*;
#(
    parameter int NUM_LEDS     = LSP_NUM_LEDS,
    parameter int PWM_BITS     = LSP_PWM_BITS,
    parameter int BLANK_CYCLES = LSP_BLANK_CYCLES
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        enable,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_LEDS)-1:0] wr_idx,
    input  logic [3*PWM_BITS-1:0]       wr_rgb,
    output logic                        frame_start,
    output logic [2:0]                  user_leds_color,
    output logic [NUM_LEDS-1:0]         user_leds_en
);

    localparam int IDX_W = $clog2(NUM_LEDS);
    localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLK_W-1:0] BLANK_LAST = BLK_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] SLOT_LAST  = IDX_W'(NUM_LEDS - 1);

    typedef struct packed {
        logic [PWM_BITS-1:0] r;
        logic [PWM_BITS-1:0] g;
        logic [PWM_BITS-1:0] b;
    } duty_t;

    duty_t               shadow    [NUM_LEDS];
    duty_t               active_p0 [NUM_LEDS];
    scan_state_t         state_p0;
    logic [IDX_W-1:0]    slot_p0;
    logic [BLK_W-1:0]    blank_cnt_p0;
    logic [PWM_BITS-1:0] pwm_cnt_p0;
    duty_t               cur_duty_p0;
    logic [2:0]          lit_n_p0;

    function automatic logic [PWM_BITS-1:0] shape_duty(input logic [PWM_BITS-1:0] d);
`ifdef LED_SCAN_PWM_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return d;
`endif
    endfunction

    function automatic duty_t shape_rgb(input duty_t v);
        duty_t o;
        o.r = shape_duty(v.r);
        o.g = shape_duty(v.g);
        o.b = shape_duty(v.b);
        return o;
    endfunction

    // Shadow buffer: host writes land here at any time, including while scanning is disabled.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_LEDS; i++) shadow[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_idx == IDX_W'(i)) shadow[i] <= wr_rgb;
            end
        end
    end

    // Stage p0: scan FSM, slot/blank/PWM counters and the shadow-to-active copy at frame start.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_p0     <= ST_BLANK;
            slot_p0      <= '0;
            blank_cnt_p0 <= '0;
            pwm_cnt_p0   <= '0;
            frame_start  <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) active_p0[i] <= '0;
        end else begin
            frame_start <= 1'b0;
            if (!enable) begin
                state_p0     <= ST_BLANK;
                slot_p0      <= '0;
                blank_cnt_p0 <= '0;
                pwm_cnt_p0   <= '0;
            end else begin
                case (state_p0)
                    ST_BLANK: begin
                        if (blank_cnt_p0 == BLANK_LAST) begin
                            blank_cnt_p0 <= '0;
                            pwm_cnt_p0   <= '0;
                            state_p0     <= ST_ON;
                            if (slot_p0 == '0) begin
                                frame_start <= 1'b1;
                                for (int i = 0; i < NUM_LEDS; i++) active_p0[i] <= shape_rgb(shadow[i]);
                            end
                        end else begin
                            blank_cnt_p0 <= blank_cnt_p0 + 1'b1;
                        end
                    end
                    ST_ON: begin
                        pwm_cnt_p0 <= pwm_cnt_p0 + 1'b1;
                        if (pwm_cnt_p0 == '1) begin
                            state_p0 <= ST_BLANK;
                            slot_p0  <= (slot_p0 == SLOT_LAST) ? '0 : slot_p0 + 1'b1;
                        end
                    end
                    default: state_p0 <= ST_BLANK;
                endcase
            end
        end
    end

    always_comb begin
        cur_duty_p0 = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (slot_p0 == IDX_W'(i)) cur_duty_p0 = active_p0[i];
        end
    end

    led_pwm_cmp #(.PWM_BITS(PWM_BITS)) u_cmp_r (
        .pwm_cnt (pwm_cnt_p0),
        .duty    (cur_duty_p0.r),
        .lit_n   (lit_n_p0[2])
    );

    led_pwm_cmp #(.PWM_BITS(PWM_BITS)) u_cmp_g (
        .pwm_cnt (pwm_cnt_p0),
        .duty    (cur_duty_p0.g),
        .lit_n   (lit_n_p0[1])
    );

    led_pwm_cmp #(.PWM_BITS(PWM_BITS)) u_cmp_b (
        .pwm_cnt (pwm_cnt_p0),
        .duty    (cur_duty_p0.b),
        .lit_n   (lit_n_p0[0])
    );

    // Stage p1: pin registers; enable and colour share one decision so they can never disagree.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !enable || state_p0 != ST_ON) begin
            user_leds_en    <= '0;
            user_leds_color <= 3'b111;
        end else begin
            user_leds_en    <= NUM_LEDS'(1) << slot_p0;
            user_leds_color <= lit_n_p0;
        end
    end

endmodule

// File: tb/tb_led_scan_pwm.sv
// Bench for led_scan_pwm: the stimulus queues one expected record per displayed slot and a
// monitor compares each slot (length, lit counts, gap, frame_start) when its enable drops.
module tb_led_scan_pwm;
    import led_scan_pkg::*;

    localparam int NL       = 7;
    localparam int SLOT_LEN = 256;
    localparam int BLANK    = 4;
    localparam int FRAME    = 1820;
    localparam int LIMIT    = 4000;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          enable  = 1'b1;
    logic          wr_en   = 1'b0;
    logic [2:0]    wr_idx  = '0;
    logic [23:0]   wr_rgb  = '0;
    logic          frame_start;
    logic [2:0]    user_leds_color;
    logic [NL-1:0] user_leds_en;

    led_scan_pwm dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .enable          (enable),
        .wr_en           (wr_en),
        .wr_idx          (wr_idx),
        .wr_rgb          (wr_rgb),
        .frame_start     (frame_start),
        .user_leds_color (user_leds_color),
        .user_leds_en    (user_leds_en)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int slot;
        int on_len;
        int r;
        int g;
        int b;
        int gap;
        int fs;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    rgb_t shad [NL];
    rgb_t disp [NL];
    bit   mon_on = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Lit cycles per slot for a duty: 0x80 -> 128 (64 with gamma), 0xFF -> 255 (254), 0x01 -> 1 (0).
    function automatic int lit_of(input logic [7:0] d);
`ifdef LED_SCAN_PWM_GAMMA_EN
        return (int'(d) * int'(d)) >> 8;
`else
        return int'(d);
`endif
    endfunction

    task automatic push_frame(input bit first, input int nslots);
        rec_t r;
        for (int s = 0; s < nslots; s++) begin
            r.slot   = s;
            r.on_len = SLOT_LEN;
            r.r      = lit_of(disp[s].r);
            r.g      = lit_of(disp[s].g);
            r.b      = lit_of(disp[s].b);
            r.gap    = (first && s == 0) ? -1 : BLANK;
            r.fs     = (s == 0) ? 1 : 0;
            exp_q.push_back(r);
        end
    endtask

    task automatic do_write(input int idx, input rgb_t v);
        wr_en  = 1'b1;
        wr_idx = idx[2:0];
        wr_rgb = v;
        @(negedge sys_clk);
        wr_en  = 1'b0;
        if (idx < NL) shad[idx] = v;
    endtask

    task automatic wait_fs(output int at);
        int k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (frame_start !== 1'b1 && k < LIMIT);
        if (frame_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_start: no pulse within %0d cycles", LIMIT);
            finish_run();
        end
        at = cyc;
    endtask

    task automatic wait_en(input logic [NL-1:0] want);
        int k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (user_leds_en !== want && k < LIMIT);
        if (user_leds_en !== want) begin
            checks++;
            errors++;
            $display("FAIL wait_enable: en=%b never reached %b", user_leds_en, want);
            finish_run();
        end
    endtask

    // Monitor state: one open slot at a time, closed when the enables go dark or change.
    bit            in_slot = 1'b0;
    logic [NL-1:0] cur_en  = '0;
    int on_len = 0, lr = 0, lg = 0, lb = 0;
    int gap_run = 0, dark_lit = 0;
    int gap_open = 0, dark_open = 0, fs_open = 0;
    bit fs_prev = 1'b0;

    task automatic close_rec();
        rec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_slot: en=%b len=%0d with nothing queued", cur_en, on_len);
            return;
        end
        e = exp_q.pop_front();
        chk("slot_en", int'(cur_en), 1 << e.slot);
        chk("slot_len", on_len, e.on_len);
        chk("r_lit", lr, e.r);
        chk("g_lit", lg, e.g);
        chk("b_lit", lb, e.b);
        chk("fs_before_slot", fs_open, e.fs);
        chk("gap_colour_dark", dark_open, 0);
        if (e.gap >= 0) chk("gap_len", gap_open, e.gap);
    endtask

    initial begin
        forever begin
            @(negedge sys_clk);
            if (mon_on) begin
                if (user_leds_en != '0) begin
                    if (in_slot && user_leds_en != cur_en) begin
                        close_rec();
                        in_slot = 1'b0;
                    end
                    if (!in_slot) begin
                        in_slot   = 1'b1;
                        cur_en    = user_leds_en;
                        on_len    = 0;
                        lr        = 0;
                        lg        = 0;
                        lb        = 0;
                        gap_open  = gap_run;
                        dark_open = dark_lit;
                        fs_open   = fs_prev ? 1 : 0;
                        gap_run   = 0;
                        dark_lit  = 0;
                    end
                    on_len++;
                    if (!user_leds_color[2]) lr++;
                    if (!user_leds_color[1]) lg++;
                    if (!user_leds_color[0]) lb++;
                end else begin
                    if (in_slot) begin
                        close_rec();
                        in_slot = 1'b0;
                    end
                    gap_run++;
                    if (user_leds_color !== 3'b111) dark_lit++;
                end
                fs_prev = (frame_start === 1'b1);
            end
        end
    end

    initial begin
        int   t0, t1;
        rgb_t v1;
        rec_t r;
        for (int i = 0; i < NL; i++) begin
            shad[i] = '0;
            disp[i] = '0;
        end

        repeat (3) @(negedge sys_clk);
        chk("rst_color", int'(user_leds_color), 7);
        chk("rst_en", int'(user_leds_en), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        mon_on  = 1'b1;
        sys_rst = 1'b0;
        t0 = cyc;
        wait_fs(t1);
        chk("startup_latency", t1 - t0, BLANK);
        push_frame(1'b1, NL);

        t0 = t1;
        wait_fs(t1);
        chk("frame_period_1", t1 - t0, FRAME);
        push_frame(1'b0, NL);
        do_write(2, 24'h8000FF);

        t0 = t1;
        wait_fs(t1);
        chk("frame_period_2", t1 - t0, FRAME);
        disp = shad;
        push_frame(1'b0, NL);

        // Mid-frame update of the slot on display, then an out-of-range index next to a valid one.
        wait_en(7'b0001000);
        do_write(3, 24'h402010);
        wait_en(7'b0100000);
        do_write(7, 24'hFFFFFF);
        do_write(0, 24'h8001FF);

        // Write timed onto the shadow-to-active copy edge: must wait one more frame.
        wait_en(7'b1000000);
        wait_en(7'b0000000);
        repeat (2) @(negedge sys_clk);
        v1     = 24'hFF8001;
        wr_en  = 1'b1;
        wr_idx = 3'd1;
        wr_rgb = v1;
        @(negedge sys_clk);
        wr_en = 1'b0;
        chk("copy_cycle_fs", int'(frame_start), 1);
        t1 = cyc;
        disp = shad;
        push_frame(1'b0, NL);
        shad[1] = v1;

        t0 = t1;
        wait_fs(t1);
        chk("frame_period_4", t1 - t0, FRAME);
        disp = shad;
        push_frame(1'b0, 4);
        r.slot   = 4;
        r.on_len = 101;
        r.r      = (lit_of(disp[4].r) < 101) ? lit_of(disp[4].r) : 101;
        r.g      = (lit_of(disp[4].g) < 101) ? lit_of(disp[4].g) : 101;
        r.b      = (lit_of(disp[4].b) < 101) ? lit_of(disp[4].b) : 101;
        r.gap    = BLANK;
        r.fs     = 0;
        exp_q.push_back(r);

        // Disable during slot 4 at display cycle 100.
        wait_en(7'b0010000);
        repeat (100) @(negedge sys_clk);
        enable = 1'b0;
        @(negedge sys_clk);
        chk("disable_en", int'(user_leds_en), 0);
        chk("disable_color", int'(user_leds_color), 7);
        do_write(4, 24'hFFFFFF);
        repeat (8) @(negedge sys_clk);
        chk("disabled_en_hold", int'(user_leds_en), 0);
        chk("disabled_fs_hold", int'(frame_start), 0);

        enable = 1'b1;
        t0 = cyc;
        wait_fs(t1);
        chk("reenable_latency", t1 - t0, BLANK);
        disp = shad;
        push_frame(1'b1, NL);

        t0 = t1;
        wait_fs(t1);
        chk("frame_period_6", t1 - t0, FRAME);
        enable = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("queue_drained", exp_q.size(), 0);
        finish_run();
    end

endmodule
